// File: rtl/sampler_trigger_if.sv
// Control/status bundle between the CSR bridge and the trigger sequencer.
//   master : CSR bridge side, drives arm/abort/sw_force and the cfg_* fields,
//            reads back state/busy/done_pulse/trig_count.
//   slave  : trigger sequencer side.
// The software trigger is called sw_force because "force" is reserved in SV.
interface sampler_trigger_if #(
  parameter int width       = 32,
  parameter int holdoffBits = 16,
  parameter int countBits   = 16
);
  logic                   arm;
  logic                   abort;
  logic                   sw_force;
  logic [width-1:0]       cfg_mask;
  logic [width-1:0]       cfg_value;
  logic                   cfg_edge;
  logic [holdoffBits-1:0] cfg_holdoff;
  logic [2:0]             state;
  logic                   busy;
  logic                   done_pulse;
  logic [countBits-1:0]   trig_count;

  modport master (
    output arm, abort, sw_force, cfg_mask, cfg_value, cfg_edge, cfg_holdoff,
    input  state, busy, done_pulse, trig_count
  );

  modport slave (
    input  arm, abort, sw_force, cfg_mask, cfg_value, cfg_edge, cfg_holdoff,
    output state, busy, done_pulse, trig_count
  );
endinterface

// File: rtl/sampler_trigger.sv
// Trigger sequencer for the capture-memory sampler (sample-clock domain).
// Arms on command, latches match/mask/edge/holdoff config, waits for a
// trigger on the sampled word, counts the holdoff, then holds the sampler's
// write reset_n high until the sampler reports done.
// Ports:
//   clk, reset_n : sample clock, synchronous active-low reset
//   csr          : CSR-side commands, config and status (slave modport)
//   sample_in    : current sample word (same bus as the sampler's w_in)
//   s_done       : sampler done flag, only looked at in CAPTURE
//   s_reset_n    : registered sampler write reset_n, high only in CAPTURE
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | waiting for arm
// ARMED   | config latched, looking for a trigger event
// DELAY   | counting holdoff cycles after the trigger
// CAPTURE | sampler released, waiting for s_done
// DONE    | capture complete, re-arm allowed
module sampler_trigger #(
  parameter int width       = 32,
  parameter int holdoffBits = 16,
  parameter int countBits   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  sampler_trigger_if.slave csr,
  input  logic [width-1:0] sample_in,
  input  logic             s_done,
  output logic             s_reset_n
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_DELAY   = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]             state_q, state_d;
  logic                   s_reset_n_q, s_reset_n_d;
  logic                   done_pulse_q, done_pulse_d;
  logic [countBits-1:0]   trig_count_q, trig_count_d;
  logic [width-1:0]       mask_q, mask_d;
  logic [width-1:0]       value_q, value_d;
  logic                   edge_q, edge_d;
  logic [holdoffBits-1:0] holdoff_q, holdoff_d;
  logic [holdoffBits-1:0] delay_cnt_q, delay_cnt_d;
  logic                   prev_match_q, prev_match_d;
  logic                   match;
  logic                   trig;

  always_comb begin
    match = (((sample_in ^ value_q) & mask_q) == '0);
    trig  = csr.sw_force | (edge_q ? (match & ~prev_match_q) : match);

    state_d      = state_q;
    done_pulse_d = 1'b0;
    trig_count_d = trig_count_q;
    mask_d       = mask_q;
    value_d      = value_q;
    edge_d       = edge_q;
    holdoff_d    = holdoff_q;
    delay_cnt_d  = delay_cnt_q;
    prev_match_d = (state_q == ST_ARMED) ? match : prev_match_q;

    if (csr.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (csr.arm) begin
            state_d      = ST_ARMED;
            mask_d       = csr.cfg_mask;
            value_d      = csr.cfg_value;
            edge_d       = csr.cfg_edge;
            holdoff_d    = csr.cfg_holdoff;
            // cleared so a match on the first ARMED cycle counts as an edge
            prev_match_d = 1'b0;
          end
        end
        ST_ARMED: begin
          if (trig) begin
            trig_count_d = trig_count_q + countBits'(1);
            if (holdoff_q != '0) begin
              state_d     = ST_DELAY;
              delay_cnt_d = holdoff_q;
            end else begin
              state_d = ST_CAPTURE;
            end
          end
        end
        ST_DELAY: begin
          // loaded with holdoff on entry, so exit on 1 gives holdoff cycles
          delay_cnt_d = delay_cnt_q - holdoffBits'(1);
          if (delay_cnt_q <= holdoffBits'(1)) state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (s_done) begin
            state_d      = ST_DONE;
            done_pulse_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    s_reset_n_d = (state_d == ST_CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      s_reset_n_q  <= 1'b0;
      done_pulse_q <= 1'b0;
      trig_count_q <= '0;
      mask_q       <= '0;
      value_q      <= '0;
      edge_q       <= 1'b0;
      holdoff_q    <= '0;
      delay_cnt_q  <= '0;
      prev_match_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_reset_n_q  <= s_reset_n_d;
      done_pulse_q <= done_pulse_d;
      trig_count_q <= trig_count_d;
      mask_q       <= mask_d;
      value_q      <= value_d;
      edge_q       <= edge_d;
      holdoff_q    <= holdoff_d;
      delay_cnt_q  <= delay_cnt_d;
      prev_match_q <= prev_match_d;
    end
  end

  assign s_reset_n      = s_reset_n_q;
  assign csr.state      = state_q;
  assign csr.busy       = (state_q == ST_ARMED) || (state_q == ST_DELAY) ||
                          (state_q == ST_CAPTURE);
  assign csr.done_pulse = done_pulse_q;
  assign csr.trig_count = trig_count_q;

endmodule

// File: tb/tb_sampler_trigger.sv
// Directed bench for sampler_trigger with a behavioural sampler
// (timeBits=4: 16 writes while reset_n is high, then done).
module tb_sampler_trigger;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] sample_in;
  logic        s_done;
  logic        s_reset_n;

  logic [4:0]  wcnt;
  logic [31:0] first_word;
  logic        ramp_en;
  logic [1:0]  exp_cnt;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          nd;

  sampler_trigger_if #(.width(32), .holdoffBits(16), .countBits(2)) bus ();

  sampler_trigger #(.width(32), .holdoffBits(16), .countBits(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .csr       (bus.slave),
    .sample_in (sample_in),
    .s_done    (s_done),
    .s_reset_n (s_reset_n)
  );

  always #5 clk = ~clk;

  // sampler write side model
  always @(posedge clk) begin
    if (!s_reset_n) begin
      wcnt   <= '0;
      s_done <= 1'b0;
    end else if (!s_done) begin
      if (wcnt == 5'd0) first_word <= sample_in;
      wcnt <= wcnt + 5'd1;
      if (wcnt == 5'd15) s_done <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (ramp_en) sample_in = sample_in + 32'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int n = 0;
    while (bus.state !== target && n < budget) begin
      step();
      n++;
    end
    chk(tag, {29'd0, bus.state}, {29'd0, target});
  endtask

  task automatic arm_cfg(input logic [31:0] m, input logic [31:0] v, input logic e,
                         input logic [15:0] h);
    bus.cfg_mask = m; bus.cfg_value = v; bus.cfg_edge = e; bus.cfg_holdoff = h;
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; sample_in = '0; ramp_en = 1'b0; exp_cnt = '0;
    bus.arm = 1'b0; bus.abort = 1'b0; bus.sw_force = 1'b0;
    bus.cfg_mask = '0; bus.cfg_value = '0; bus.cfg_edge = 1'b0; bus.cfg_holdoff = '0;
    step(); step();
    chk("rst_state", {29'd0, bus.state}, 32'd0);
    chk("rst_srst", {31'd0, s_reset_n}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_pulse", {31'd0, bus.done_pulse}, 32'd0);
    chk("rst_cnt", {30'd0, bus.trig_count}, 32'd0);
    reset_n = 1'b1;
    step();

    // level trigger on ramp, cfg_value changed while ARMED
    sample_in = 32'h40;
    arm_cfg(32'hFF, 32'h42, 1'b0, 16'd0);
    bus.cfg_value = 32'h99;
    chk("lvl_armed", {29'd0, bus.state}, 32'd1);
    chk("lvl_busy", {31'd0, bus.busy}, 32'd1);
    chk("lvl_srst_lo", {31'd0, s_reset_n}, 32'd0);
    ramp_en = 1'b1;
    step(); step();
    chk("lvl_still_armed", {29'd0, bus.state}, 32'd1);
    step();
    exp_cnt++;
    chk("lvl_capture", {29'd0, bus.state}, 32'd3);
    chk("lvl_srst_hi", {31'd0, s_reset_n}, 32'd1);
    chk("lvl_cnt", {30'd0, bus.trig_count}, {30'd0, exp_cnt});
    wait_state(3'd4, 40, "lvl_done");
    chk("lvl_pulse", {31'd0, bus.done_pulse}, 32'd1);
    chk("lvl_first", first_word, 32'h43);
    chk("lvl_nwrites", {27'd0, wcnt}, 32'd16);
    chk("lvl_done_srst", {31'd0, s_reset_n}, 32'd0);
    chk("lvl_done_busy", {31'd0, bus.busy}, 32'd0);
    ramp_en = 1'b0;
    step();
    chk("lvl_pulse_once", {31'd0, bus.done_pulse}, 32'd0);
    chk("lvl_hold_done", {29'd0, bus.state}, 32'd4);

    // edge mode, input held at 1 while arming, twice (second is a re-arm)
    sample_in = 32'h1;
    arm_cfg(32'h1, 32'h1, 1'b1, 16'd0);
    chk("edge1_armed", {29'd0, bus.state}, 32'd1);
    step();
    exp_cnt++;
    chk("edge1_capture", {29'd0, bus.state}, 32'd3);
    chk("edge1_cnt", {30'd0, bus.trig_count}, {30'd0, exp_cnt});
    wait_state(3'd4, 40, "edge1_done");
    arm_cfg(32'h1, 32'h1, 1'b1, 16'd0);
    step();
    exp_cnt++;
    chk("edge2_capture", {29'd0, bus.state}, 32'd3);
    chk("edge2_cnt", {30'd0, bus.trig_count}, {30'd0, exp_cnt});
    wait_state(3'd4, 40, "edge2_done");

    // edge mode: 1 at arm, 0 on first ARMED cycle, then 1 triggers
    sample_in = 32'h1;
    arm_cfg(32'h1, 32'h1, 1'b1, 16'd0);
    sample_in = 32'h0;
    step();
    chk("edge3_armed", {29'd0, bus.state}, 32'd1);
    sample_in = 32'h1;
    step();
    exp_cnt++;
    chk("edge3_capture", {29'd0, bus.state}, 32'd3);
    chk("edge3_cnt_wrap", {30'd0, bus.trig_count}, {30'd0, exp_cnt});
    wait_state(3'd4, 40, "edge3_done");

    // holdoff 5, trigger at 0x10
    sample_in = 32'h0E;
    arm_cfg(32'hFF, 32'h10, 1'b0, 16'd5);
    ramp_en = 1'b1;
    step(); step();
    chk("hold_armed", {29'd0, bus.state}, 32'd1);
    step();
    exp_cnt++;
    chk("hold_delay", {29'd0, bus.state}, 32'd2);
    nd = 0;
    while (bus.state === 3'd2 && nd < 20) begin
      nd++;
      step();
    end
    chk("hold_ncycles", nd, 32'd5);
    chk("hold_capture", {29'd0, bus.state}, 32'd3);
    wait_state(3'd4, 40, "hold_done");
    chk("hold_first", first_word, 32'h16);
    chk("hold_cnt", {30'd0, bus.trig_count}, {30'd0, exp_cnt});
    ramp_en = 1'b0;

    // abort in ARMED
    sample_in = 32'h0;
    arm_cfg(32'hFF, 32'h77, 1'b0, 16'd0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abA_state", {29'd0, bus.state}, 32'd0);
    chk("abA_srst", {31'd0, s_reset_n}, 32'd0);
    chk("abA_cnt", {30'd0, bus.trig_count}, {30'd0, exp_cnt});

    // abort in DELAY
    arm_cfg(32'h0, 32'h0, 1'b0, 16'd10);
    step();
    exp_cnt++;
    chk("abD_delay", {29'd0, bus.state}, 32'd2);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abD_state", {29'd0, bus.state}, 32'd0);
    chk("abD_cnt", {30'd0, bus.trig_count}, {30'd0, exp_cnt});

    // arm ignored in CAPTURE, then abort in CAPTURE
    arm_cfg(32'h0, 32'h0, 1'b0, 16'd0);
    step();
    exp_cnt++;
    step();
    chk("abC_srst_hi", {31'd0, s_reset_n}, 32'd1);
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    chk("armC_ignored", {29'd0, bus.state}, 32'd3);
    chk("armC_cnt", {30'd0, bus.trig_count}, {30'd0, exp_cnt});
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abC_state", {29'd0, bus.state}, 32'd0);
    chk("abC_srst", {31'd0, s_reset_n}, 32'd0);
    chk("abC_pulse", {31'd0, bus.done_pulse}, 32'd0);
    step();
    chk("abC_pulse2", {31'd0, bus.done_pulse}, 32'd0);
    chk("abC_cnt", {30'd0, bus.trig_count}, {30'd0, exp_cnt});

    // arm + abort together in IDLE
    bus.arm = 1'b1; bus.abort = 1'b1;
    step();
    bus.arm = 1'b0; bus.abort = 1'b0;
    chk("armabort_idle", {29'd0, bus.state}, 32'd0);

    // reset for one cycle in DELAY
    arm_cfg(32'h0, 32'h0, 1'b0, 16'd10);
    step();
    chk("rstD_delay", {29'd0, bus.state}, 32'd2);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    exp_cnt = '0;
    chk("rstD_state", {29'd0, bus.state}, 32'd0);
    chk("rstD_srst", {31'd0, s_reset_n}, 32'd0);
    chk("rstD_busy", {31'd0, bus.busy}, 32'd0);
    chk("rstD_pulse", {31'd0, bus.done_pulse}, 32'd0);
    chk("rstD_cnt", {30'd0, bus.trig_count}, 32'd0);

    // four forced runs with a non-matching input: count 1,2,3,0
    sample_in = 32'h0;
    for (int i = 0; i < 4; i++) begin
      arm_cfg(32'hFF, 32'h55, 1'b0, 16'd0);
      step();
      chk("frc_armed", {29'd0, bus.state}, 32'd1);
      bus.sw_force = 1'b1;
      step();
      bus.sw_force = 1'b0;
      exp_cnt++;
      chk("frc_capture", {29'd0, bus.state}, 32'd3);
      chk("frc_cnt", {30'd0, bus.trig_count}, {30'd0, exp_cnt});
      wait_state(3'd4, 40, "frc_done");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sampler_trigger.md
Name: sampler_trigger

Overview:
- Trigger sequencer for the capture-memory sampler. Runs in the sample-clock domain and drives the sampler's write-side reset_n.
- Arms on command and latches a match/mask/edge configuration. It waits for a trigger on the sampled word, then counts a programmable holdoff. After that it releases the sampler to capture exactly 2**timeBits words and reports completion.
- Sits between the CSR bridge (arm/abort/config) and the sampler write port. sample_in is the same bus that feeds the sampler's w_in.

Parameters:
- width, 32, sample word width in bits.
- holdoffBits, 16, width of the holdoff counter.
- countBits, 16, width of the trigger event counter.

Ports:
- clk  in  1  sample clock
- reset_n  in  1  synchronous, active-low reset
- sample_in  in  width  current sample word, also fed to the sampler
- arm  in  1  single-cycle arm request
- abort  in  1  return to IDLE from any state
- force  in  1  software trigger, effective only in ARMED
- cfg_mask  in  width  bits that participate in the match
- cfg_value  in  width  match value
- cfg_edge  in  1  0 = level match, 1 = rising-edge of match
- cfg_holdoff  in  holdoffBits  cycles between trigger and capture start
- s_done  in  1  sampler done flag
- s_reset_n  out  1  sampler write reset_n, registered
- state  out  3  IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, DONE=4
- busy  out  1  state is ARMED, DELAY or CAPTURE
- done_pulse  out  1  one-cycle pulse on CAPTURE->DONE
- trig_count  out  countBits  triggers accepted since reset, wraps modulo 2**countBits

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-low.
- Reset values: state=IDLE, s_reset_n=0, busy=0, done_pulse=0, trig_count=0, all latched config and counters 0, prev_match=0.
- Match (combinational): match = ((sample_in ^ mask_q) & mask_q... precisely, ((sample_in XOR value_q) AND mask_q) == 0, using the latched mask_q and value_q. If mask_q=0, match is always 1.
- Trigger event in ARMED: force OR (edge_q ? match AND NOT prev_match : match).
  - prev_match is registered every cycle while in ARMED.
  - prev_match is cleared on entry to ARMED, so a match on the first ARMED cycle counts as an edge.
- Config latching: cfg_mask, cfg_value, cfg_edge and cfg_holdoff are latched on the edge that accepts arm. Later changes to the cfg_* inputs have no effect until the next arm.
- Priority each cycle: reset_n low > abort > arm > trigger / counter / s_done.
- Transitions:
  - IDLE: arm -> ARMED.
  - ARMED: trigger event -> DELAY if holdoff_q != 0, else CAPTURE. trig_count increments on that edge.
  - DELAY: counter loaded with holdoff_q on entry, decrements each cycle. It spends exactly holdoff_q cycles in DELAY, then -> CAPTURE.
  - CAPTURE: s_done=1 -> DONE; done_pulse=1 for exactly the following cycle.
  - DONE: arm -> ARMED (re-arm, new config latched); otherwise hold.
  - abort in any state -> IDLE. No done_pulse; trig_count unchanged.
  - arm while busy is ignored.
  - arm and abort in the same cycle -> IDLE.
- s_reset_n: registered; equals 1 iff state==CAPTURE. It is low in every other state, including DONE.
  - ARMED always lasts at least 1 cycle, so the sampler always sees at least 1 low cycle before capture and its done flag is 0 on entry to CAPTURE.
  - s_done is ignored outside CAPTURE.
- Latency: if the trigger word is presented in cycle T, the first word written to the sampler is the one presented in cycle T+holdoff_q+1. Capture ends 2**timeBits cycles later, when the sampler's s_done rises.
- Mid-capture abort: s_reset_n drops on the next edge and the sampler's contents are undefined.
- Reset mid-operation: same as the reset values above, from any state.
- trig_count wraps from all-ones to 0 without a flag.

Test Plan:
- Level trigger, width=32, sampler timeBits=4, mask=0x000000FF, value=0x42, holdoff=0. Sample ramp 0x40,0x41,0x42,... -> ARMED to CAPTURE on the 0x42 edge; first captured word 0x43; DONE after 16 captures; one done_pulse; trig_count=1.
- Edge mode, mask=0x1, value=0x1, input held at 0x1 while arming -> trigger on the first ARMED cycle. Re-arm from DONE with input held at 0x1 -> again triggers immediately (prev_match cleared). Toggling input 1,0,1 from an armed state that began at 0 -> triggers at the second 1.
- Holdoff=5, trigger at ramp value 0x10 -> exactly 5 cycles in DELAY; first captured word 0x16.
- Abort injected in ARMED, DELAY and CAPTURE -> state IDLE and s_reset_n=0 next cycle; no done_pulse; trig_count unchanged by the abort.
- cfg_value changed 0x42 -> 0x99 while ARMED -> still triggers on 0x42. arm pulsed during CAPTURE -> ignored. arm+abort same cycle in IDLE -> stays IDLE.
- trig_count with countBits=2: four force-triggered runs -> reads 1,2,3,0. reset_n low for 1 cycle in DELAY -> all outputs at reset values next cycle.
